// File: rtl/syn_fifo_prog_flags.sv
// Single-clock FIFO with independent programmable almost-empty/almost-full
// thresholds, registered read data with valid strobe, and sticky error flags.
module syn_fifo_prog_flags #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int DEF_AE = 4,
  parameter int DEF_AF = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             cfg_we_i,
  input  logic [PW-1:0]    cfg_ae_i,
  input  logic [PW-1:0]    cfg_af_i,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             half_o,
  output logic             ae_o,
  output logic             af_o,
  output logic             af_ae_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    ae_reg, af_reg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, overflow, underflow;
  logic             rd_ok, wr_ok;

  // Flags decode only registered state, so no input reaches an output combinationally.
  assign empty_o     = (count == '0);
  assign full_o      = (count == CW'(DEPTH));
  assign half_o      = (count >= CW'(DEPTH / 2));
  assign ae_o        = (count <= {1'b0, ae_reg});
  assign af_o        = (count >= (CW'(DEPTH) - {1'b0, af_reg}));
  assign af_ae_o     = ae_o | af_o;
  assign count_o     = count;
  assign rd_data_o   = rd_data;
  assign rd_valid_o  = rd_valid;
  assign overflow_o  = overflow;
  assign underflow_o = underflow;

  // Write-while-full only succeeds when a read frees a slot in the same cycle.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && wr_ok) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (cfg_we_i) begin
        ae_reg <= cfg_ae_i;
        af_reg <= cfg_af_i;
      end else begin
        ae_reg <= PW'(DEF_AE);
        af_reg <= PW'(DEF_AF);
      end
    end else begin
      if (cfg_we_i) begin
        ae_reg <= cfg_ae_i;
        af_reg <= cfg_af_i;
      end
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= rd_ok;
      count    <= count + CW'(wr_ok) - CW'(rd_ok);
      if (wr_en_i & full_o & ~rd_ok) overflow <= 1'b1;
      if (rd_en_i & empty_o) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_fifo_prog_flags.sv
// Directed bench for syn_fifo_prog_flags (DEPTH=16, WIDTH=8, DEF_AE=DEF_AF=4).
module tb_syn_fifo_prog_flags;

  logic       sys_clk, sys_rst;
  logic       wr_en_i, rd_en_i, cfg_we_i;
  logic [7:0] wr_data_i, rd_data_o;
  logic       rd_valid_o;
  logic [3:0] cfg_ae_i, cfg_af_i;
  logic [4:0] count_o;
  logic       empty_o, full_o, half_o, ae_o, af_o, af_ae_o, overflow_o, underflow_o;

  int n_vec = 0;
  int n_err = 0;

  syn_fifo_prog_flags #(.DEPTH(16), .WIDTH(8), .DEF_AE(4), .DEF_AF(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .cfg_we_i(cfg_we_i), .cfg_ae_i(cfg_ae_i), .cfg_af_i(cfg_af_i),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .half_o(half_o),
    .ae_o(ae_o), .af_o(af_o), .af_ae_o(af_ae_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock with the given requests; outputs are sampled 1 ns after the edge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    wr_en_i = wr; wr_data_i = wd; rd_en_i = rd;
    @(posedge sys_clk); #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0;
  endtask

  task automatic do_reset(input logic user, input logic [3:0] ae, input logic [3:0] af);
    sys_rst = 1'b1; cfg_we_i = user; cfg_ae_i = ae; cfg_af_i = af;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; cfg_we_i = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; cfg_we_i = 1'b0;
    wr_data_i = '0; cfg_ae_i = '0; cfg_af_i = '0;
    #2;

    // 1: default thresholds
    do_reset(1'b0, 4'd0, 4'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_half", 32'(half_o), 32'd0);
    chk("rst_ae", 32'(ae_o), 32'd1);
    chk("rst_af", 32'(af_o), 32'd0);
    chk("rst_af_ae", 32'(af_ae_o), 32'd1);
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_unf", 32'(underflow_o), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("def_count", 32'(count_o), 32'(i));
      chk("def_ae", 32'(ae_o), 32'(i <= 4));
      chk("def_af", 32'(af_o), 32'(i >= 12));
      chk("def_af_ae", 32'(af_ae_o), 32'(i <= 4 || i >= 12));
      chk("def_full", 32'(full_o), 32'(i == 16));
      chk("def_half", 32'(half_o), 32'(i >= 8));
    end

    // 2: user thresholds ae=2, af=3
    do_reset(1'b1, 4'd2, 4'd3);
    chk("usr_rst_ae", 32'(ae_o), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("usr_ae", 32'(ae_o), 32'(i <= 2));
      chk("usr_af", 32'(af_o), 32'(i >= 13));
      chk("usr_af_ae", 32'(af_ae_o), 32'(i <= 2 || i >= 13));
    end

    // 3: overflow, ordering, underflow
    do_reset(1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("rd_valid", 32'(rd_valid_o), 32'd1);
      chk("rd_data", 32'(rd_data_o), 32'(i));
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("drain_unf", 32'(underflow_o), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("unf_set", 32'(underflow_o), 32'd1);
    chk("unf_valid", 32'(rd_valid_o), 32'd0);
    chk("unf_hold", 32'(rd_data_o), 32'h10);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // 4: simultaneous read+write at full and at empty
    do_reset(1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    chk("rw_full_count", 32'(count_o), 32'd16);
    chk("rw_full_ovf", 32'(overflow_o), 32'd0);
    chk("rw_full_data", 32'(rd_data_o), 32'h01);
    for (int i = 2; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("rw_rd_data", 32'(rd_data_o), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1);
    chk("rw_last_data", 32'(rd_data_o), 32'h55);
    chk("rw_last_empty", 32'(empty_o), 32'd1);
    step(1'b1, 8'h77, 1'b1);
    chk("rw_empty_count", 32'(count_o), 32'd1);
    chk("rw_empty_valid", 32'(rd_valid_o), 32'd0);
    chk("rw_empty_unf", 32'(underflow_o), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("rw_empty_data", 32'(rd_data_o), 32'h77);
    chk("rw_empty_vld2", 32'(rd_valid_o), 32'd1);

    // 5: runtime reconfig at count 8
    do_reset(1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    chk("cfg_pre_ae", 32'(ae_o), 32'd0);
    cfg_we_i = 1'b1; cfg_ae_i = 4'd9; cfg_af_i = 4'd4;
    step(1'b0, 8'h00, 1'b0);
    cfg_we_i = 1'b0;
    chk("cfg_ae", 32'(ae_o), 32'd1);
    chk("cfg_af", 32'(af_o), 32'd0);
    chk("cfg_count", 32'(count_o), 32'd8);

    // 6: reset mid-stream at count 10, with a write request at the reset edge
    step(1'b1, 8'h09, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    chk("mid_count10", 32'(count_o), 32'd10);
    wr_en_i = 1'b1; wr_data_i = 8'hEE;
    do_reset(1'b0, 4'd0, 4'd0);
    wr_en_i = 1'b0;
    chk("mid_count", 32'(count_o), 32'd0);
    chk("mid_empty", 32'(empty_o), 32'd1);
    chk("mid_ovf", 32'(overflow_o), 32'd0);
    chk("mid_ae_def", 32'(ae_o), 32'd1);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_rd_data", 32'(rd_data_o), 32'h3C);
    chk("mid_rd_valid", 32'(rd_valid_o), 32'd1);
    chk("mid_end_empty", 32'(empty_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
